// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// stall/flush sequencer (slave).
interface pipe_hazard_ctrl_if;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       ex_memtoreg;
    logic [4:0] ex_wraddr;
    logic       ex_branch_taken;
    logic       ex_mdu_start;
    logic       mem_req;
    logic       mem_ready;

    logic       if_stall;
    logic       id_stall;
    logic       ex_stall;
    logic       mem_stall;
    logic       ifid_flush;
    logic       idex_flush;
    logic       exmem_bubble;
    logic       memwb_bubble;
    logic       mdu_busy;
    logic [1:0] state;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_memtoreg, ex_wraddr,
               ex_branch_taken, ex_mdu_start, mem_req, mem_ready,
        input  if_stall, id_stall, ex_stall, mem_stall, ifid_flush,
               idex_flush, exmem_bubble, memwb_bubble, mdu_busy, state
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_memtoreg, ex_wraddr,
               ex_branch_taken, ex_mdu_start, mem_req, mem_ready,
        output if_stall, id_stall, ex_stall, mem_stall, ifid_flush,
               idex_flush, exmem_bubble, memwb_bubble, mdu_busy, state
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use interlock, taken
// branch flush, data-memory wait states and multi-cycle MDU occupancy.
module pipe_hazard_ctrl #(
    parameter int unsigned MDU_CYCLES = 32,
    parameter int unsigned CNT_W      = 6
) (
    input logic               clk,
    input logic               rst_n,
    pipe_hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_MDU_BUSY = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic miss;
    logic load_use;
    logic cnt_last;

    logic if_stall, id_stall, ex_stall, mem_stall;
    logic ifid_flush, idex_flush, exmem_bubble, memwb_bubble;

    assign miss     = hz.mem_req & ~hz.mem_ready;
    assign load_use = hz.ex_memtoreg && (hz.ex_wraddr != 5'd0) &&
                      ((hz.ex_wraddr == hz.id_rs) ||
                       (hz.id_uses_rt && (hz.ex_wraddr == hz.id_rt)));
    // Busy cycle whose decrement brings the counter to zero ends the
    // occupancy: start cycle plus MDU_CYCLES-1 busy cycles.
    assign cnt_last = (cnt_q <= CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN, ST_MEM_WAIT: begin
                if ((state_q == ST_MEM_WAIT) && !hz.mem_ready) begin
                    state_d = ST_MEM_WAIT;
                end else if (miss) begin
                    state_d = ST_MEM_WAIT;
                end else if (hz.ex_mdu_start) begin
                    cnt_d   = CNT_LOAD;
                    state_d = (MDU_CYCLES > 1) ? ST_MDU_BUSY : ST_RUN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_MDU_BUSY: begin
                cnt_d = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
                if (cnt_last) begin
                    state_d = miss ? ST_MEM_WAIT : ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        if_stall     = 1'b0;
        id_stall     = 1'b0;
        ex_stall     = 1'b0;
        mem_stall    = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_bubble = 1'b0;
        memwb_bubble = 1'b0;
        case (state_q)
            ST_RUN, ST_MEM_WAIT: begin
                // A ready MEM_WAIT cycle has miss==0, so it falls through to
                // the RUN priority chain and MEM/WB captures the load data.
                if (((state_q == ST_MEM_WAIT) && !hz.mem_ready) || miss) begin
                    if_stall     = 1'b1;
                    id_stall     = 1'b1;
                    ex_stall     = 1'b1;
                    mem_stall    = 1'b1;
                    memwb_bubble = 1'b1;
                end else if (hz.ex_mdu_start) begin
                    if_stall     = 1'b1;
                    id_stall     = 1'b1;
                    ex_stall     = 1'b1;
                    exmem_bubble = 1'b1;
                end else if (hz.ex_branch_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (load_use) begin
                    if_stall   = 1'b1;
                    id_stall   = 1'b1;
                    idex_flush = 1'b1;
                end
            end
            ST_MDU_BUSY: begin
                if ((cnt_q != '0) || miss) begin
                    if_stall = 1'b1;
                    id_stall = 1'b1;
                    ex_stall = 1'b1;
                    if (miss) begin
                        mem_stall    = 1'b1;
                        memwb_bubble = 1'b1;
                    end else begin
                        exmem_bubble = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        if (!rst_n) begin
            if_stall     = 1'b0;
            id_stall     = 1'b0;
            ex_stall     = 1'b0;
            mem_stall    = 1'b0;
            ifid_flush   = 1'b0;
            idex_flush   = 1'b0;
            exmem_bubble = 1'b0;
            memwb_bubble = 1'b0;
        end
    end

    assign hz.if_stall     = if_stall;
    assign hz.id_stall     = id_stall;
    assign hz.ex_stall     = ex_stall;
    assign hz.mem_stall    = mem_stall;
    assign hz.ifid_flush   = ifid_flush;
    assign hz.idex_flush   = idex_flush;
    assign hz.exmem_bubble = exmem_bubble;
    assign hz.memwb_bubble = memwb_bubble;
    assign hz.mdu_busy     = rst_n && (state_q == ST_MDU_BUSY);
    assign hz.state        = rst_n ? 2'(state_q) : 2'b00;

endmodule
